// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch response stage (inst_buffer and its queues).
package fetch_pkg;

   localparam int FETCH_XLEN = 64;
   localparam int FETCH_ILEN = 32;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef struct packed {
      logic                  stale;
      logic [FETCH_XLEN-1:0] pc;
   } pcq_entry_t;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_ILEN-1:0] instr;
      logic                  fault;
   } ibuf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with count, clear, and an optional stale-mark-all hook on the entry MSB.
module sync_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter bit STALE_EN = 1'b0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     clear,
   input  logic                     mark_stale,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   count_nxt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] stale_q, stale_d;
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign count     = cnt_q;
   assign count_nxt = cnt_d;
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mem_d   = mem_q;
      stale_d = stale_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (clear) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q]   = push_data;
            stale_d[wr_q] = push_data[WIDTH-1];
            wr_d          = wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
      // Marking after the write covers an entry pushed in the same cycle.
      if (mark_stale) begin
         stale_d = '1;
      end
   end

   // NOTE: sequential state is assigned only with <= so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         stale_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      head = mem_q[rd_q];
      if (STALE_EN) begin
         head[WIDTH-1] = stale_q[rd_q];
      end
   end

endmodule

// File: rtl/inst_buffer.sv
// Fetch response stage: pairs AR PCs with R beats and queues {pc, instr, fault} for decode.
// Optional INST_BUFFER_BYPASS_EN: a live beat with an empty queue and a ready decoder goes straight out.
module inst_buffer
   import fetch_pkg::*;
#(
   parameter int XLEN  = FETCH_XLEN,
   parameter int ILEN  = FETCH_ILEN,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_ar_fire,
   input  logic [XLEN-1:0] i_ar_addr,
   input  logic            i_rvalid,
   output logic            o_rready,
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_rresp,
   input  logic            i_flush,
   output logic            o_halt_n,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [ILEN-1:0] o_instr,
   output logic            o_fault
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;

   pcq_entry_t  pcq_push_data, pcq_head;
   ibuf_entry_t beat, ifq_head;
   logic        pcq_full, pcq_empty, ifq_full, ifq_empty;
   logic [CW-1:0] pcq_count, pcq_count_nxt, ifq_count, ifq_count_nxt;
   logic [OW-1:0] occ_nxt;
   logic        head_stale, r_fire, live_beat, bypass_take, ifq_push, ifq_pop;
   logic        halt_n_q, halt_n_d;
   logic        unused_rdata;

   assign unused_rdata = ^i_rdata[XLEN-1:ILEN];

   assign pcq_push_data = '{stale: 1'b0, pc: i_ar_addr};

   sync_fifo #(.WIDTH($bits(pcq_entry_t)), .DEPTH(DEPTH), .STALE_EN(1'b1)) u_pcq (
      .clk        (clk),
      .rstn       (rstn),
      .push       (i_ar_fire),
      .push_data  (pcq_push_data),
      .pop        (r_fire),
      .clear      (1'b0),
      .mark_stale (i_flush),
      .head       (pcq_head),
      .full       (pcq_full),
      .empty      (pcq_empty),
      .count      (pcq_count),
      .count_nxt  (pcq_count_nxt)
   );

   sync_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(DEPTH), .STALE_EN(1'b0)) u_ifq (
      .clk        (clk),
      .rstn       (rstn),
      .push       (ifq_push),
      .push_data  (beat),
      .pop        (ifq_pop),
      .clear      (i_flush),
      .mark_stale (1'b0),
      .head       (ifq_head),
      .full       (ifq_full),
      .empty      (ifq_empty),
      .count      (ifq_count),
      .count_nxt  (ifq_count_nxt)
   );

   always_comb begin
      head_stale = !pcq_empty && pcq_head.stale;
`ifdef INST_BUFFER_BYPASS_EN
      o_rready    = head_stale || !ifq_full || i_ready;
`else
      o_rready    = head_stale || !ifq_full;
`endif
      r_fire      = i_rvalid && o_rready;
      live_beat   = r_fire && !head_stale && !i_flush;
      beat        = '{pc: pcq_head.pc, instr: i_rdata[ILEN-1:0], fault: (i_rresp != RESP_OKAY)};
`ifdef INST_BUFFER_BYPASS_EN
      bypass_take = live_beat && ifq_empty && i_ready;
`else
      bypass_take = 1'b0;
`endif
      ifq_push    = live_beat && !bypass_take;
      ifq_pop     = !ifq_empty && i_ready && !i_flush;

      o_valid = 1'b0;
      o_pc    = '0;
      o_instr = '0;
      o_fault = 1'b0;
      if (bypass_take) begin
         o_valid = 1'b1;
         o_pc    = beat.pc;
         o_instr = beat.instr;
         o_fault = beat.fault;
      end else if (!ifq_empty) begin
         o_valid = 1'b1;
         o_pc    = ifq_head.pc;
         o_instr = ifq_head.instr;
         o_fault = ifq_head.fault;
      end

      // Two free entries are kept for ARs already in flight in the fetch pipeline.
      occ_nxt  = {1'b0, pcq_count_nxt} + {1'b0, ifq_count_nxt};
      halt_n_d = (occ_nxt <= OW'(DEPTH - 2));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         halt_n_q <= 1'b1;
      end else begin
         halt_n_q <= halt_n_d;
      end
   end

   assign o_halt_n = halt_n_q;

   a_ar_when_full: assert property (@(posedge clk) disable iff (!rstn)
      !(i_ar_fire && pcq_full && !r_fire));

   a_r_when_empty: assert property (@(posedge clk) disable iff (!rstn)
      !(i_rvalid && pcq_empty));

   logic unused_counts;
   assign unused_counts = ^{pcq_count, ifq_count};

endmodule
